cpu_clk_ctrl: RTL



---
 rtl/cpu_clk_ctrl_if.sv | 60 ++++++
 rtl/cpu_clk_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl_if
// Groups the run-control inputs and the phase/status outputs of cpu_clk_ctrl.
//
// Modports:
//   master : run-control source (drives start/step/stop/halt/max_instr,
//            observes phases and status)
//   slave  : cpu_clk_ctrl itself
//
// Signals:
//   start, step, stop, halt, max_instr[ICNT_W]          control -> controller
//   cntrl_clk, clk, fetch, alu_clk, phase[4]            controller -> cpu
//   running, done, timeout, instr_count[ICNT_W]         controller status
//
// Optional macro CPU_CLK_CTRL_BP_EN adds bp_en, bp_addr[AW], pc_addr[AW]
// (inputs to the controller) and bp_hit (output).
// -----------------------------------------------------------------------------
interface cpu_clk_ctrl_if #(
    parameter int ICNT_W = 16,
    parameter int AW     = 5
);
    logic              start;
    logic              step;
    logic              stop;
    logic              halt;
    logic [ICNT_W-1:0] max_instr;
    logic              cntrl_clk;
    logic              clk;
    logic              fetch;
    logic              alu_clk;
    logic [3:0]        phase;
    logic              running;
    logic              done;
    logic              timeout;
    logic [ICNT_W-1:0] instr_count;
`ifdef CPU_CLK_CTRL_BP_EN
    logic              bp_en;
    logic [AW-1:0]     bp_addr;
    logic [AW-1:0]     pc_addr;
    logic              bp_hit;
`endif

    modport master (
        output start, step, stop, halt, max_instr,
`ifdef CPU_CLK_CTRL_BP_EN
        output bp_en, bp_addr, pc_addr,
        input  bp_hit,
`endif
        input  cntrl_clk, clk, fetch, alu_clk, phase, running, done, timeout, instr_count
    );

    modport slave (
        input  start, step, stop, halt, max_instr,
`ifdef CPU_CLK_CTRL_BP_EN
        input  bp_en, bp_addr, pc_addr,
        output bp_hit,
`endif
        output cntrl_clk, clk, fetch, alu_clk, phase, running, done, timeout, instr_count
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
// Clock-phase generator and run controller for the cpu core. Divides
// master_clk into 16-cycle instructions, decodes the cntrl_clk/clk/fetch/
// alu_clk phases, and gates them on instruction boundaries under
// start/step/stop control. Execution ends on cpu halt or when the retired
// instruction count reaches a non-zero budget.
//
// Ports:
//   master_clk : master clock, all state on rising edge
//   rst_       : asynchronous active-low reset
//   bus        : cpu_clk_ctrl_if.slave (control inputs, phases, status)
//
// Optional macro CPU_CLK_CTRL_BP_EN enables a PC breakpoint that stops RUN
// at a boundary into the BREAK state (bp_en/bp_addr/pc_addr/bp_hit).
// -----------------------------------------------------------------------------
module cpu_clk_ctrl #(
    parameter int ICNT_W = 16,
    parameter int AW     = 5
) (
    input  logic          master_clk,
    input  logic          rst_,
    cpu_clk_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED,
        S_TIMEOUT
`ifdef CPU_CLK_CTRL_BP_EN
        , S_BREAK
`endif
    } state_t;

    localparam logic [ICNT_W-1:0] COUNT_MAX = '1;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ICNT_W-1:0] icount, icount_nxt, icount_inc;
    logic              halt_pend, halt_pend_nxt;
    logic              stop_pend, stop_pend_nxt;
    logic              in_exec, next_exec, boundary, budget_hit;
    logic              cntrl_clk_q, clk_q, fetch_q, alu_clk_q;
    logic              running_q, done_q, timeout_q;
`ifdef CPU_CLK_CTRL_BP_EN
    logic              bp_match;
    logic              bp_hit_q;
`endif

    assign in_exec    = (state == S_RUN) || (state == S_STEP);
    assign boundary   = in_exec && (cnt == 4'hF);
    assign icount_inc = (icount == COUNT_MAX) ? icount : icount + 1'b1;
    // Budget is compared against the count this boundary will produce
    assign budget_hit = (bus.max_instr != '0) && (icount_inc == bus.max_instr);
`ifdef CPU_CLK_CTRL_BP_EN
    assign bp_match   = bus.bp_en && (bus.pc_addr == bus.bp_addr);
`endif

    // Next-state, counter and sticky-request logic
    always_comb begin
        state_nxt  = state;
        icount_nxt = icount;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt  = S_RUN;
                    icount_nxt = '0;
                end else if (bus.step) begin
                    state_nxt  = S_STEP;
                    icount_nxt = '0;
                end
            end
            S_RUN: begin
                if (boundary) begin
                    icount_nxt = icount_inc;
                    if (halt_pend || bus.halt)
                        state_nxt = S_HALTED;
                    else if (budget_hit)
                        state_nxt = S_TIMEOUT;
`ifdef CPU_CLK_CTRL_BP_EN
                    else if (bp_match)
                        state_nxt = S_BREAK;
`endif
                    else if (stop_pend || bus.stop)
                        state_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                // Breakpoints are deliberately not checked so a step can leave one
                if (boundary) begin
                    icount_nxt = icount_inc;
                    if (halt_pend || bus.halt)
                        state_nxt = S_HALTED;
                    else if (budget_hit)
                        state_nxt = S_TIMEOUT;
                    else
                        state_nxt = S_IDLE;
                end
            end
            S_HALTED, S_TIMEOUT
`ifdef CPU_CLK_CTRL_BP_EN
            , S_BREAK
`endif
            : begin
                if (bus.start) begin
                    state_nxt  = S_RUN;
                    icount_nxt = '0;
                end else if (bus.step) begin
                    state_nxt = S_STEP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        next_exec = (state_nxt == S_RUN) || (state_nxt == S_STEP);
        // Phase count wraps F->0 on the last boundary, so leaving RUN/STEP lands on 0
        cnt_nxt   = in_exec ? cnt + 4'd1 : 4'd0;

        halt_pend_nxt = next_exec && (halt_pend || (in_exec && bus.halt));
        stop_pend_nxt = next_exec && (stop_pend || (in_exec && bus.stop));
    end

    // State, counters and registered outputs; phase flops load from cnt_nxt
    // so they stay exactly aligned with phase
    always_ff @(posedge master_clk or negedge rst_) begin
        if (!rst_) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            icount      <= '0;
            halt_pend   <= 1'b0;
            stop_pend   <= 1'b0;
            cntrl_clk_q <= 1'b1;
            clk_q       <= 1'b0;
            fetch_q     <= 1'b1;
            alu_clk_q   <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef CPU_CLK_CTRL_BP_EN
            bp_hit_q    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            icount      <= icount_nxt;
            halt_pend   <= halt_pend_nxt;
            stop_pend   <= stop_pend_nxt;
            cntrl_clk_q <= ~cnt_nxt[0];
            clk_q       <= cnt_nxt[1];
            fetch_q     <= ~cnt_nxt[3];
            alu_clk_q   <= (cnt_nxt != 4'hC);
            running_q   <= next_exec;
            done_q      <= (state_nxt == S_HALTED);
            timeout_q   <= (state_nxt == S_TIMEOUT);
`ifdef CPU_CLK_CTRL_BP_EN
            bp_hit_q    <= (state_nxt == S_BREAK);
`endif
        end
    end

    assign bus.cntrl_clk   = cntrl_clk_q;
    assign bus.clk         = clk_q;
    assign bus.fetch       = fetch_q;
    assign bus.alu_clk     = alu_clk_q;
    assign bus.phase       = cnt;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.instr_count = icount;
`ifdef CPU_CLK_CTRL_BP_EN
    assign bus.bp_hit      = bp_hit_q;
`endif

endmodule
